// File: rtl/usb_audio_pkg.sv
// Shared types and constants for the USB audio gain stage.
package usb_audio_pkg;
  localparam int GAIN_W     = 9;
  localparam int GAIN_UNITY = 256;
  localparam int SAMPLE_W   = 16;
  localparam int NUM_CH     = 2;
  localparam int SHIFT      = $clog2(GAIN_UNITY);

  typedef logic [GAIN_W-1:0] gain_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_MUL0    = 3'd2,
    ST_MUL1    = 3'd3,
    ST_OUTPUT  = 3'd4
  } state_e;

  // Move g toward t by at most step, never past t.
  function automatic gain_t ramp_step(input gain_t g, input gain_t t,
                                      input logic [GAIN_W:0] step);
    logic [GAIN_W:0] up;
    logic [GAIN_W:0] dn;
    logic [GAIN_W:0] gap;
    up  = {1'b0, g} + step;
    dn  = {1'b0, g} - step;
    gap = {1'b0, g} - {1'b0, t};
    if (g < t)      ramp_step = (up > {1'b0, t}) ? t : up[GAIN_W-1:0];
    else if (g > t) ramp_step = (gap > step) ? dn[GAIN_W-1:0] : t;
    else            ramp_step = g;
  endfunction
endpackage

// File: rtl/usb_audio_clk_sync.sv
// Audio_Clk synchroniser with a one-cycle pulse on the synced rising edge.
module usb_audio_clk_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~last_q;
endmodule

// File: rtl/usb_audio_gain.sv
// Stereo soft-ramped gain stage: one shared multiplier, one registered
// output pair per Audio_Clk period.
module usb_audio_gain
  import usb_audio_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RAMP_STEP   = 1
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             Active,
  input  logic                             Mute,
  input  logic [NUM_CH-1:0][7:0]           Volume,
  input  logic                             Audio_Clk,
  input  logic [NUM_CH-1:0][SAMPLE_W-1:0]  Audio,
  output logic [NUM_CH-1:0][SAMPLE_W-1:0]  Out_Audio,
  output logic                             Out_Valid
);
  // Only the low SAMPLE_W+SHIFT bits of the product survive the shift and
  // truncation, so the multiplier is kept at that width.
  localparam int PROD_W = SAMPLE_W + SHIFT;
  localparam logic [GAIN_W:0] STEP = (GAIN_W+1)'(RAMP_STEP);

  state_e                           state_q, state_d;
  logic                             rise, pending_q, mul_sel;
  gain_t [NUM_CH-1:0]               gain_q, target;
  logic [NUM_CH-1:0][SAMPLE_W-1:0]  smp_q;
  logic [SAMPLE_W-1:0]              res0_q;
  logic [PROD_W-1:0]                prod_q, mul_a, mul_b;

  usb_audio_clk_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (Clk),
    .rst      (Reset),
    .async_in (Audio_Clk),
    .rise     (rise)
  );

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_target
    assign target[ch] = (Mute | ~Active) ? '0 : {1'b0, Volume[ch]} + 9'd1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (rise | pending_q) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_MUL0;
      ST_MUL0:    state_d = ST_MUL1;
      ST_MUL1:    state_d = ST_OUTPUT;
      ST_OUTPUT:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  assign mul_sel = (state_q == ST_MUL1);
  assign mul_a   = {{(PROD_W-SAMPLE_W){smp_q[mul_sel][SAMPLE_W-1]}}, smp_q[mul_sel]};
  assign mul_b   = {{(PROD_W-GAIN_W){1'b0}}, gain_q[mul_sel]};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      gain_q    <= '0;
      smp_q     <= '0;
      prod_q    <= '0;
      res0_q    <= '0;
      Out_Audio <= '0;
      Out_Valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      Out_Valid <= 1'b0;
      // A rise arriving during CAPTURE must survive the clear.
      if (state_q == ST_CAPTURE)    pending_q <= rise;
      else if (state_q != ST_IDLE)  pending_q <= pending_q | rise;
      case (state_q)
        ST_CAPTURE: begin
          smp_q <= Audio;
          for (int c = 0; c < NUM_CH; c++)
            gain_q[c] <= ramp_step(gain_q[c], target[c], STEP);
        end
        ST_MUL0: prod_q <= mul_a * mul_b;
        ST_MUL1: begin
          res0_q <= prod_q[SHIFT +: SAMPLE_W];
          prod_q <= mul_a * mul_b;
        end
        ST_OUTPUT: begin
          Out_Audio[0] <= res0_q;
          Out_Audio[1] <= prod_q[SHIFT +: SAMPLE_W];
          Out_Valid    <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_usb_audio_gain.sv
// Randomized bench for usb_audio_gain against a per-sample gain model.
module tb_usb_audio_gain;
  localparam int SYNC_STAGES = 2;
  localparam int RAMP_STEP   = 1;

  logic             Clk = 1'b0, Reset = 1'b1, Active = 1'b0, Mute = 1'b0;
  logic             Audio_Clk = 1'b0;
  logic [1:0][7:0]  Volume = '0;
  logic [1:0][15:0] Audio = '0;
  logic [1:0][15:0] Out_Audio;
  logic             Out_Valid;

  usb_audio_gain #(.SYNC_STAGES(SYNC_STAGES), .RAMP_STEP(RAMP_STEP)) dut (
    .Clk(Clk), .Reset(Reset), .Active(Active), .Mute(Mute), .Volume(Volume),
    .Audio_Clk(Audio_Clk), .Audio(Audio), .Out_Audio(Out_Audio), .Out_Valid(Out_Valid)
  );

  always #5 Clk = ~Clk;

  int          n_tests = 0, n_fail = 0, strobes = 0;
  int          gm[2] = '{0, 0};
  logic [31:0] exp_q[$];
  logic [31:0] prev_out = '0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int ramp(input int g, input int t);
    if (g < t) return (g + RAMP_STEP > t) ? t : g + RAMP_STEP;
    if (g > t) return (g - RAMP_STEP < t) ? t : g - RAMP_STEP;
    return g;
  endfunction

  function automatic logic [15:0] scale(input logic [15:0] s, input int g);
    int p;
    p = ($signed(s) * g) >>> 8;
    return p[15:0];
  endfunction

  // One new sample: advance model gains from current controls, queue the pair.
  task automatic model_push(input logic [15:0] l, input logic [15:0] r);
    int t;
    logic [15:0] o[2];
    for (int ch = 0; ch < 2; ch++) begin
      t = (Mute || !Active) ? 0 : int'(Volume[ch]) + 1;
      gm[ch] = ramp(gm[ch], t);
      o[ch] = scale(ch == 0 ? l : r, gm[ch]);
    end
    exp_q.push_back({o[1], o[0]});
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r);
    @(negedge Clk);
    Audio = {r, l};
    repeat (3) @(negedge Clk);
    model_push(l, r);
    Audio_Clk = 1'b1;
    repeat (8) @(negedge Clk);
    Audio_Clk = 1'b0;
    repeat (8) @(negedge Clk);
  endtask

  // Every strobe must match the model; outside strobes the output must hold.
  always @(posedge Clk) begin
    logic [31:0] e;
    #1;
    if (!Reset) begin
      if (Out_Valid) begin
        strobes++;
        if (exp_q.size() == 0) chk("unexpected_strobe", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_l", int'($signed(Out_Audio[0])), int'($signed(e[15:0])));
          chk("out_r", int'($signed(Out_Audio[1])), int'($signed(e[31:16])));
        end
      end else chk("hold", int'(Out_Audio), int'(prev_out));
    end
    prev_out = Out_Audio;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int vk, s0;
    repeat (3) @(negedge Clk);
    chk("reset_out_l", int'(Out_Audio[0]), 0);
    chk("reset_out_r", int'(Out_Audio[1]), 0);
    chk("reset_valid", int'(Out_Valid), 0);
    Reset = 1'b0;
    Volume = {8'd255, 8'd255};
    Active = 1'b1;

    // Latency from first Clk edge seeing Audio_Clk high.
    @(negedge Clk);
    Audio = {16'hFB2E, 16'h4000};
    repeat (3) @(negedge Clk);
    model_push(16'h4000, 16'hFB2E);
    Audio_Clk = 1'b1;
    vk = -1;
    for (int k = 0; k < 10; k++) begin
      @(posedge Clk); #2;
      if (Out_Valid && vk < 0) vk = k;
    end
    chk("latency", vk, SYNC_STAGES + 4);
    chk("first_l", int'($signed(Out_Audio[0])), 64);
    chk("first_r", int'($signed(Out_Audio[1])), -5);
    @(negedge Clk);
    Audio_Clk = 1'b0;
    repeat (8) @(negedge Clk);

    // Ramp to unity over 256 samples.
    for (int i = 0; i < 254; i++) send(16'($urandom), 16'($urandom));
    send(16'h4000, 16'hFB2E);
    chk("unity_l", int'($signed(Out_Audio[0])), 16'sh4000);
    chk("unity_r", int'($signed(Out_Audio[1])), -1234);

    // Down to half gain.
    Volume = {8'd127, 8'd127};
    for (int i = 0; i < 127; i++) send(16'($urandom), 16'($urandom));
    send(16'h8000, 16'h7FFF);
    chk("half_l", int'($signed(Out_Audio[0])), -16384);
    chk("half_r", int'($signed(Out_Audio[1])), 16383);

    // Soft mute from unity.
    Volume = {8'd255, 8'd255};
    for (int i = 0; i < 128; i++) send(16'($urandom), 16'($urandom));
    Mute = 1'b1;
    for (int n = 1; n <= 260; n++) begin
      send(16'h7FFF, 16'($urandom));
      chk("mute_ramp", int'($signed(Out_Audio[0])), n < 256 ? (32767 * (256 - n)) >>> 8 : 0);
    end
    chk("mute_r_zero", int'(Out_Audio[1]), 0);

    // Reset during MUL0 aborts the pair.
    Mute = 1'b0;
    for (int i = 0; i < 4; i++) send(16'h7FFF, 16'h8001);
    chk("pre_reset_l", int'($signed(Out_Audio[0])), (32767 * 4) >>> 8);
    @(negedge Clk);
    Audio = {16'h1234, 16'h4321};
    repeat (3) @(negedge Clk);
    model_push(16'h4321, 16'h1234);
    Audio_Clk = 1'b1;
    repeat (4) @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("abort_out", int'(Out_Audio), 0);
    chk("abort_valid", int'(Out_Valid), 0);
    exp_q.delete();
    gm = '{0, 0};
    @(negedge Clk);
    Audio_Clk = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    s0 = strobes;
    repeat (20) @(negedge Clk);
    chk("no_strobe_after_reset", strobes - s0, 0);

    // Three rises 2 Clk apart: one processed, one pending, one dropped.
    Audio = {16'h1000, 16'h7000};
    repeat (3) @(negedge Clk);
    model_push(16'h7000, 16'h1000);
    model_push(16'h7000, 16'h1000);
    s0 = strobes;
    for (int i = 0; i < 3; i++) begin
      Audio_Clk = 1'b1;
      @(negedge Clk);
      Audio_Clk = 1'b0;
      @(negedge Clk);
    end
    repeat (20) @(negedge Clk);
    chk("burst_strobes", strobes - s0, 2);
    chk("burst_queue_empty", exp_q.size(), 0);

    // Interface deselected ramps down.
    Active = 1'b0;
    for (int i = 0; i < 4; i++) send(16'($urandom), 16'($urandom));
    chk("inactive_zero", int'(Out_Audio), 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
